// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {pc, instr} pairs feeding decode.
module fetch_buffer #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32,
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output logic               head_valid,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop & head_valid;
  assign do_push    = push & ((count != FULL) | do_pop);

  // Empty head reads as zero so decode never sees stale entries.
  assign head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;
  assign head_instr = head_valid ? instr_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  // Flush wins over push and pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem requests,
// redirect handling and the decode-facing instruction buffer.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       INSTR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEFAULT),
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  link_pc
);

  localparam int unsigned       CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0]  BUF_FULL = CNT_W'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);

  fetch_state_e      state;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_d;
  logic              req_d;
  logic [ADDR_W-1:0] addr_d;
  logic              push;
  logic              flush;
  logic              pop;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] redirect_target;
  logic              unused_redirect_lsb;

  assign redirect_target     = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign pop                 = instr_valid & instr_ready;
  assign link_pc             = instr_pc + STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
    end
  end

  // Redirect takes priority; an ack arriving with it still retires the request.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    req_d   = imem_req;
    addr_d  = imem_addr;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = redirect_target;
      unique case (state)
        FETCH: begin
          state_d = FETCH;
          req_d   = 1'b0;
        end
        WAIT, DISCARD: begin
          if (imem_ack) begin
            state_d = FETCH;
            req_d   = 1'b0;
          end else begin
            state_d = DISCARD;
          end
        end
        default: begin
          state_d = FETCH;
          req_d   = 1'b0;
        end
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (count < BUF_FULL) begin
            req_d   = 1'b1;
            addr_d  = pc;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            push    = 1'b1;
            pc_d    = pc + STEP;
            req_d   = 1'b0;
            state_d = FETCH;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = FETCH;
          end
        end
        default: begin
          req_d   = 1'b0;
          state_d = FETCH;
        end
      endcase
    end
  end

  fetch_buffer #(
    .DEPTH   (BUF_DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (pc),
    .push_instr (imem_rdata),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .head_valid (instr_valid),
    .head_pc    (instr_pc),
    .head_instr (instr_out)
  );

endmodule
